// File: rtl/adc_sample_sequencer.sv
// Sequences channel-0 then channel-1 conversions on one shared spi2adc per sampling tick.
// Optional averaged output enabled by defining SEQ_MIX_EN.
module adc_sample_sequencer #(
  parameter int unsigned DW      = 10,
  parameter int unsigned TIMEOUT = 2000,
  parameter int unsigned CW      = 12
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          tick,
  input  logic          clr_err,
  output logic          adc_start,
  output logic          adc_channel,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [DW-1:0] ch0_sample,
  output logic [DW-1:0] ch1_sample,
  output logic [DW-1:0] mix_out,
  output logic          samples_valid,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err
);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START0 = 3'd1,
    WAIT0  = 3'd2,
    START1 = 3'd3,
    WAIT1  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [DW-1:0] hold0, hold1;
  logic          load0_c, load1_c, timeout_c, overrun_c;

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus the one-cycle events that feed the registered outputs.
  always_comb begin
    state_next = state;
    load0_c    = 1'b0;
    load1_c    = 1'b0;
    timeout_c  = 1'b0;
    overrun_c  = tick && (state != IDLE);
    case (state)
      IDLE:   if (tick) state_next = START0;
      START0: state_next = WAIT0;
      WAIT0: begin
        if (adc_valid) begin
          load0_c    = 1'b1;
          state_next = START1;
        end else if (cnt == TO_LAST) begin
          timeout_c  = 1'b1;
          state_next = IDLE;
        end
      end
      START1: state_next = WAIT1;
      WAIT1: begin
        if (adc_valid) begin
          load1_c    = 1'b1;
          state_next = DONE;
        end else if (cnt == TO_LAST) begin
          timeout_c  = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      adc_start     <= 1'b0;
      adc_channel   <= 1'b0;
      cnt           <= '0;
      hold0         <= '0;
      hold1         <= '0;
      ch0_sample    <= '0;
      ch1_sample    <= '0;
      samples_valid <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      adc_start <= (state == START0) || (state == START1);
      if (state == START0)      adc_channel <= 1'b0;
      else if (state == START1) adc_channel <= 1'b1;

      if ((state == START0) || (state == START1))   cnt <= '0;
      else if ((state == WAIT0) || (state == WAIT1)) cnt <= cnt + CW'(1);

      if (load0_c) hold0 <= adc_data;
      if (load1_c) hold1 <= adc_data;

      // Both channels publish together so the consumer never sees a mixed pair.
      samples_valid <= (state == DONE);
      if (state == DONE) begin
        ch0_sample <= hold0;
        ch1_sample <= hold1;
      end

      busy        <= (state_next != IDLE);
      overrun     <= overrun_c | (overrun & ~clr_err);
      timeout_err <= timeout_c | (timeout_err & ~clr_err);
    end
  end

`ifdef SEQ_MIX_EN
  logic [DW:0] mix_sum_c;
  assign mix_sum_c = {1'b0, hold0} + {1'b0, hold1};

  always_ff @(posedge sysclk) begin
    if (reset)              mix_out <= '0;
    else if (state == DONE) mix_out <= mix_sum_c[DW:1];
  end
`else
  assign mix_out = '0;
`endif

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer with a behavioural spi2adc responder.
// Expected mix values follow SEQ_MIX_EN when the bench is built with the same define.
module tb_adc_sample_sequencer;
  localparam int unsigned DW      = 10;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned CW      = 12;
`ifdef SEQ_MIX_EN
  localparam bit MIX = 1'b1;
`else
  localparam bit MIX = 1'b0;
`endif

  logic          sysclk = 1'b0;
  logic          reset, tick, clr_err, adc_valid;
  logic [DW-1:0] adc_data;
  logic          adc_start, adc_channel, samples_valid, busy, overrun, timeout_err;
  logic [DW-1:0] ch0_sample, ch1_sample, mix_out;

  typedef struct packed {
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic [DW-1:0] mx;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            sv_count = 0;
  int            cyc = 0;
  int            v_cyc = 0;
  int            sv_cyc = 0;
  logic [DW-1:0] m_d0 = '0, m_d1 = '0, inj_data = '0;
  bit            m_hold1 = 1'b0;
  bit            inj_req = 1'b0;

  adc_sample_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .sysclk(sysclk), .reset(reset), .tick(tick), .clr_err(clr_err),
    .adc_start(adc_start), .adc_channel(adc_channel),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .ch0_sample(ch0_sample), .ch1_sample(ch1_sample), .mix_out(mix_out),
    .samples_valid(samples_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge sysclk);
    tick = 1'b0;
  endtask

  task automatic wait_start(input logic ch, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge sysclk);
      if (adc_start === 1'b1 && adc_channel === ch) seen = 1'b1;
    end
    check("wait_adc_start", 32'(seen), 32'(1));
  endtask

  task automatic wait_idle(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge sysclk);
      if (busy === 1'b0) seen = 1'b1;
    end
    check("wait_idle", 32'(seen), 32'(1));
  endtask

  // spi2adc model: answers each start 40 cycles later unless told to withhold ch1.
  initial begin
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge sysclk);
      if (inj_req) begin
        adc_data  = inj_data;
        adc_valid = 1'b1;
        @(negedge sysclk);
        adc_valid = 1'b0;
        inj_req   = 1'b0;
      end else if (adc_start === 1'b1) begin
        logic ch;
        ch = adc_channel;
        repeat (40) @(negedge sysclk);
        if (!(ch && m_hold1)) begin
          adc_data  = ch ? m_d1 : m_d0;
          adc_valid = 1'b1;
          v_cyc     = cyc;
          @(negedge sysclk);
          adc_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: every samples_valid pulse must match the oldest expected pair.
  initial begin
    forever begin
      @(negedge sysclk);
      if (samples_valid === 1'b1) begin
        sv_count++;
        sv_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_samples_valid: got ch0=%0h ch1=%0h expected none", ch0_sample, ch1_sample);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ch0_sample", 32'(ch0_sample), 32'(e.c0));
          check("ch1_sample", 32'(ch1_sample), 32'(e.c1));
          check("mix_out", 32'(mix_out), 32'(e.mx));
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    clr_err = 1'b0;
    step(3);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_adc_start", 32'(adc_start), 32'(0));
    check("rst_ch0", 32'(ch0_sample), 32'(0));
    check("rst_ch1", 32'(ch1_sample), 32'(0));
    check("rst_flags", 32'({overrun, timeout_err, samples_valid}), 32'(0));
    reset = 1'b0;
    step(2);

    // Test 1: basic sequence and latencies
    m_d0 = 10'h155;
    m_d1 = 10'h2AA;
    sb_q.push_back('{c0: 10'h155, c1: 10'h2AA, mx: MIX ? 10'h1FF : 10'h000});
    pulse_tick();
    check("start_at_T+1", 32'(adc_start), 32'(0));
    step(1);
    check("start_at_T+2", 32'(adc_start), 32'(1));
    check("start_ch0", 32'(adc_channel), 32'(0));
    check("busy_seq", 32'(busy), 32'(1));
    step(1);
    check("start_one_cycle", 32'(adc_start), 32'(0));
    wait_start(1'b1, 60);
    wait_idle(100);
    check("sv_latency", 32'(sv_cyc - v_cyc), 32'(2));
    check("sv_count_t1", 32'(sv_count), 32'(1));

    // Test 2: extreme data for averaging
    m_d0 = 10'h3FF;
    m_d1 = 10'h001;
    sb_q.push_back('{c0: 10'h3FF, c1: 10'h001, mx: MIX ? 10'h200 : 10'h000});
    pulse_tick();
    wait_idle(200);
    check("sv_count_t2", 32'(sv_count), 32'(2));

    // Test 3: tick mid-sequence together with clr_err; set wins
    m_d0 = 10'h155;
    m_d1 = 10'h2AA;
    sb_q.push_back('{c0: 10'h155, c1: 10'h2AA, mx: MIX ? 10'h1FF : 10'h000});
    pulse_tick();
    step(21);
    tick    = 1'b1;
    clr_err = 1'b1;
    @(negedge sysclk);
    tick    = 1'b0;
    clr_err = 1'b0;
    check("overrun_set", 32'(overrun), 32'(1));
    wait_idle(200);
    check("sv_count_t3", 32'(sv_count), 32'(3));
    check("overrun_sticky", 32'(overrun), 32'(1));
    clr_err = 1'b1;
    @(negedge sysclk);
    clr_err = 1'b0;
    check("overrun_clr", 32'(overrun), 32'(0));

    // Test 4: ch1 never answers
    m_hold1 = 1'b1;
    m_d0    = 10'h0AB;
    pulse_tick();
    wait_start(1'b1, 60);
    step(49);
    check("timeout_early", 32'(timeout_err), 32'(0));
    check("busy_before_to", 32'(busy), 32'(1));
    step(1);
    check("timeout_set", 32'(timeout_err), 32'(1));
    check("busy_after_to", 32'(busy), 32'(0));
    step(10);
    check("sv_count_t4", 32'(sv_count), 32'(3));
    check("ch0_retained", 32'(ch0_sample), 32'(10'h155));
    check("ch1_retained", 32'(ch1_sample), 32'(10'h2AA));
    m_hold1 = 1'b0;
    clr_err = 1'b1;
    @(negedge sysclk);
    clr_err = 1'b0;
    check("timeout_clr", 32'(timeout_err), 32'(0));

    // Test 5: reset in WAIT1, late data must be ignored
    m_d0 = 10'h111;
    m_d1 = 10'h222;
    pulse_tick();
    wait_start(1'b1, 60);
    step(10);
    reset = 1'b1;
    @(negedge sysclk);
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_ch0", 32'(ch0_sample), 32'(0));
    check("rst_mid_ch1", 32'(ch1_sample), 32'(0));
    check("rst_mid_start", 32'(adc_start), 32'(0));
    @(negedge sysclk);
    reset = 1'b0;
    step(40);
    check("sv_count_t5", 32'(sv_count), 32'(3));
    check("busy_after_rst", 32'(busy), 32'(0));
    check("ch0_after_rst", 32'(ch0_sample), 32'(0));
    m_d0 = 10'h2C3;
    m_d1 = 10'h07E;
    sb_q.push_back('{c0: 10'h2C3, c1: 10'h07E, mx: MIX ? 10'h1A0 : 10'h000});
    pulse_tick();
    wait_idle(200);
    check("sv_count_t5b", 32'(sv_count), 32'(4));

    // Test 6: stray adc_valid while idle
    inj_data = 10'h0F0;
    inj_req  = 1'b1;
    for (int i = 0; i < 10 && inj_req; i++) @(negedge sysclk);
    check("inject_done", 32'(inj_req), 32'(0));
    step(3);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_ch0", 32'(ch0_sample), 32'(10'h2C3));
    check("idle_ch1", 32'(ch1_sample), 32'(10'h07E));
    check("sv_count_t6", 32'(sv_count), 32'(4));

    step(2);
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
